projectile_unit: RTL

//  Per-player projectile engine: launches one bullet on a fire press, advances it once per

---
 rtl/projectile_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/projectile_unit.sv
// Per-player projectile engine: one bullet per fire press, moved on frame ticks, hit-tested against the opponent.
// Optional PROJECTILE_QUEUE_EN: remembers one fire press made during cooldown and launches it once idle.
module projectile_unit #(
    parameter int SCREEN_W = 640,
    parameter int PLAYER_W = 40,
    parameter int HURT_W   = 40,
    parameter int BULLET_W = 8,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic       facing_right,
    input  logic [9:0] shooter_x,
    input  logic [9:0] target_x,
    input  logic [2:0] game_state,
    output logic       bullet_active,
    output logic [9:0] bullet_x,
    output logic       bullet_hit,
    output logic       busy
);

    // 12-bit signed geometry: moves past either screen edge and target_x+HURT_W both fit without wrapping
    localparam int SW = 12;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef logic signed [SW-1:0] coord_t;
    typedef enum logic [1:0] {IDLE, FLIGHT, COOL} state_t;

    localparam coord_t SPEED_S  = coord_t'(SPEED);
    localparam coord_t HURT_S   = coord_t'(HURT_W);
    localparam coord_t BULLET_S = coord_t'(BULLET_W);
    localparam coord_t PLAYER_S = coord_t'(PLAYER_W);
    localparam coord_t SCREEN_S = coord_t'(SCREEN_W);
    localparam coord_t MAX_X_S  = coord_t'(SCREEN_W - BULLET_W);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
    localparam logic [CW-1:0] CD_ONE  = CW'(1);

    state_t        state, state_next;
    logic          fire_q;
    logic          dir_right, dir_right_next;
    logic [9:0]    x, x_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          hit_q, hit_next;
    logic          fire_rise, fight, launch_req;
    coord_t        cur_s, shooter_s, target_s, nx, launch_right, launch_left;
    logic          hit_now, off_now;

    assign fire_rise = fire & ~fire_q;
    assign fight     = (game_state == 3'd0);

    assign cur_s     = $signed({2'b00, x});
    assign shooter_s = $signed({2'b00, shooter_x});
    assign target_s  = $signed({2'b00, target_x});
    assign nx        = dir_right ? cur_s + SPEED_S : cur_s - SPEED_S;
    assign hit_now   = (nx < target_s + HURT_S) && (nx + BULLET_S > target_s);
    assign off_now   = nx[SW-1] || (nx + BULLET_S > SCREEN_S);

    assign launch_right = (shooter_s + PLAYER_S > MAX_X_S) ? MAX_X_S : shooter_s + PLAYER_S;
    assign launch_left  = (shooter_s < BULLET_S) ? '0 : shooter_s - BULLET_S;

`ifdef PROJECTILE_QUEUE_EN
    logic pending, pending_next;

    // A press during cooldown is held until the unit is idle again; leaving the fight drops it
    always_comb begin
        pending_next = pending;
        if (!fight)
            pending_next = 1'b0;
        else if (state == COOL && fire_rise)
            pending_next = 1'b1;
        else if (state == IDLE)
            pending_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pending <= 1'b0;
        else
            pending <= pending_next;
    end

    assign launch_req = fire_rise | pending;
`else
    assign launch_req = fire_rise;
`endif

    always_comb begin
        state_next     = state;
        x_next         = x;
        dir_right_next = dir_right;
        cnt_next       = cnt;
        hit_next       = 1'b0;
        case (state)
            IDLE: begin
                if (fight && launch_req) begin
                    state_next     = FLIGHT;
                    dir_right_next = facing_right;
                    x_next         = facing_right ? 10'(launch_right) : 10'(launch_left);
                end
            end
            FLIGHT: begin
                // Leaving the fight outranks a tick arriving in the same cycle
                if (!fight) begin
                    state_next = COOL;
                    cnt_next   = CD_LOAD;
                end else if (frame_tick) begin
                    if (hit_now) begin
                        hit_next   = 1'b1;
                        state_next = COOL;
                        cnt_next   = CD_LOAD;
                    end else if (off_now) begin
                        state_next = COOL;
                        cnt_next   = CD_LOAD;
                    end else begin
                        x_next = 10'(nx);
                    end
                end
            end
            COOL: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else if (frame_tick) begin
                    cnt_next = cnt - CD_ONE;
                    if (cnt == CD_ONE)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fire_q    <= 1'b0;
            dir_right <= 1'b0;
            x         <= '0;
            cnt       <= '0;
            hit_q     <= 1'b0;
        end else begin
            state     <= state_next;
            fire_q    <= fire;
            dir_right <= dir_right_next;
            x         <= x_next;
            cnt       <= cnt_next;
            hit_q     <= hit_next;
        end
    end

    assign bullet_active = (state == FLIGHT);
    assign busy          = (state != IDLE);
    assign bullet_x      = x;
    assign bullet_hit    = hit_q;

endmodule
